cam_fifo_writer: RTL and testbench

- Write side of the pixel line FIFO. The downscaler is the FIFO's read side.
- Takes the camera's byte-serial RGB444 stream (vsync, href, 8-bit data) and assembles byte pairs into 12-bit pixels.
- Pushes each pixel into a standard (latency-1) FIFO using fifo_wr_en/fifo_full.
- Tracks frame and line structure, and reports overflow and malformed-line errors as sticky flags.

---
 rtl/cam_fifo_writer.sv | 135 +++++++++++++
 tb/tb_cam_fifo_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_fifo_writer.sv
// Camera byte-serial RGB444 capture: pairs bytes into 12-bit pixels and writes them to a standard FIFO.
// Optional CAM_FRAME_SKIP_EN: alternate frames are parsed but not written, halving the output frame rate.
module cam_fifo_writer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        fifo_full,
  output logic [11:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err,
  input  logic        err_clr
);

  localparam logic [10:0] H_PIX_W  = 11'(H_PIXELS);
  localparam logic [9:0]  V_LINE_W = 10'(V_LINES);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, END_FRAME} state_t;

  state_t      state, state_nxt;
  logic        vsync_d, href_d;
  logic        phase;
  logic [10:0] pix_cnt;
  logic [9:0]  line_cnt;
  logic [3:0]  r_nib;

  logic vsync_rise, vsync_fall, href_fall;
  logic byte_ok, pix_wr, line_end, short_line, frame_err, write_ok, do_write, drop;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign vsync_rise = ~vsync_d & cam_vsync;
  assign vsync_fall = vsync_d & ~cam_vsync;
  assign href_fall  = href_d & ~cam_href;

  // A vsync rise takes priority over a byte in the same cycle; a line still open at that point is closed as a partial line.
  assign byte_ok    = (state == ACTIVE) & cam_href & ~vsync_rise;
  assign pix_wr     = byte_ok & phase;
  assign line_end   = (state == ACTIVE) & (href_fall | (vsync_rise & (cam_href | href_d)));
  assign short_line = line_end & ((pix_cnt != H_PIX_W) | phase);
  assign frame_err  = (state == END_FRAME) & (line_cnt != V_LINE_W);
  assign do_write   = pix_wr & ~fifo_full & write_ok;
  assign drop       = pix_wr & fifo_full & write_ok;

`ifdef CAM_FRAME_SKIP_EN
  logic frame_odd, skip_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_odd  <= 1'b0;
      skip_frame <= 1'b0;
    end else if ((state == WAIT_FRAME) && vsync_fall) begin
      skip_frame <= frame_odd;
      frame_odd  <= ~frame_odd;
    end
  end

  assign write_ok = ~skip_frame;
`else
  assign write_ok = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      WAIT_FRAME: if (vsync_fall) state_nxt = ACTIVE;
      ACTIVE:     if (vsync_rise) state_nxt = END_FRAME;
      END_FRAME: begin
        frame_done = 1'b1;
        state_nxt  = WAIT_FRAME;
      end
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_FRAME;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      phase    <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      state   <= state_nxt;
      vsync_d <= cam_vsync;
      href_d  <= cam_href;
      if ((state != ACTIVE) || line_end) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
      end else if (byte_ok) begin
        phase <= ~phase;
        if (phase) pix_cnt <= sat_inc11(pix_cnt);
      end
      if ((state == WAIT_FRAME) && vsync_fall) line_cnt <= '0;
      else if (line_end)                       line_cnt <= sat_inc10(line_cnt);
    end
  end

  // Red nibble holding register: pure data, needs no reset.
  always_ff @(posedge clk) begin
    if (byte_ok && !phase) r_nib <= cam_data[3:0];
  end

  // Output stage: registered write strobe and pixel word, sticky error flags (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      fifo_wr_en <= do_write;
      if (do_write) fifo_din <= {r_nib, cam_data};
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (short_line || frame_err) line_err <= 1'b1;
      else if (err_clr)            line_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_fifo_writer.sv
// Directed bench for cam_fifo_writer with a 4x4 frame geometry.
module tb_cam_fifo_writer;
  localparam int HP = 4;
  localparam int VL = 4;

  logic        clk = 1'b0;
  logic        rst, cam_vsync, cam_href, fifo_full, err_clr;
  logic [7:0]  cam_data;
  logic [11:0] fifo_din;
  logic        fifo_wr_en, frame_done, overflow, line_err;

  cam_fifo_writer #(.H_PIXELS(HP), .V_LINES(VL)) dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .fifo_full(fifo_full), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .frame_done(frame_done), .overflow(overflow),
    .line_err(line_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0, fd_cnt = 0, bad_din = 0, b2b = 0;
  logic prev_wr = 1'b0;
  logic [11:0] exp_din = 12'h000;

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_cnt++;
      if (fifo_din !== exp_din) bad_din++;
      if (prev_wr === 1'b1) b2b++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    prev_wr = fifo_wr_en;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    @(posedge clk);
    wr_cnt = 0; fd_cnt = 0; bad_din = 0; b2b = 0;
  endtask

  task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk); cam_href = 1'b1; cam_data = b0;
    @(negedge clk); cam_data = b1;
  endtask

  task automatic end_line();
    @(negedge clk); cam_href = 1'b0; cam_data = 8'h00;
    @(negedge clk);
  endtask

  task automatic send_line(input int np, input logic [7:0] b0, input logic [7:0] b1);
    for (int p = 0; p < np; p++) send_pix(b0, b1);
    end_line();
  endtask

  task automatic frame_start();
    @(negedge clk); cam_vsync = 1'b0;
    idle(2);
  endtask

  task automatic frame_end();
    @(negedge clk); cam_vsync = 1'b1;
    idle(4);
  endtask

  task automatic send_frame(input int nl, input logic [7:0] b0, input logic [7:0] b1);
    frame_start();
    for (int l = 0; l < nl; l++) send_line(HP, b0, b1);
    frame_end();
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    fifo_full = 1'b0; err_clr = 1'b0;
    idle(3); #1;
    n_cmp++; if (fifo_din !== 12'h000) begin n_bad++; $display("FAIL reset_din got=%h want=000", fifo_din); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b want=0", fifo_wr_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL reset_line_err got=%b want=0", line_err); end
    @(negedge clk); rst = 1'b0;
    idle(3);
  endtask

  task automatic test_basic_frame();
    exp_din = 12'h1B2;
    clr_mon();
    send_frame(VL, 8'hA1, 8'hB2);
    #1;
    n_cmp++; if (wr_cnt !== 16) begin n_bad++; $display("FAIL basic_writes got=%0d want=16", wr_cnt); end
    n_cmp++; if (bad_din !== 0) begin n_bad++; $display("FAIL basic_din_errors got=%0d want=0", bad_din); end
    n_cmp++; if (fifo_din !== 12'h1B2) begin n_bad++; $display("FAIL basic_last_din got=%h want=1b2", fifo_din); end
    n_cmp++; if (b2b !== 0) begin n_bad++; $display("FAIL basic_back_to_back got=%0d want=0", b2b); end
    n_cmp++; if (fd_cnt !== 1) begin n_bad++; $display("FAIL basic_frame_done got=%0d want=1", fd_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow got=%b want=0", overflow); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL basic_line_err got=%b want=0", line_err); end
  endtask

  task automatic test_overflow();
    exp_din = 12'hC3D;
    clr_mon();
    frame_start();
    for (int p = 0; p < HP; p++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = 8'h5C; fifo_full = (p == 2);
      @(negedge clk); cam_data = 8'h3D;
    end
    @(negedge clk); fifo_full = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    @(negedge clk);
    for (int l = 1; l < VL; l++) send_line(HP, 8'h5C, 8'h3D);
    frame_end();
    #1;
    n_cmp++; if (wr_cnt !== 15) begin n_bad++; $display("FAIL ovf_writes got=%0d want=15", wr_cnt); end
    n_cmp++; if (bad_din !== 0) begin n_bad++; $display("FAIL ovf_din_errors got=%0d want=0", bad_din); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL ovf_line_err got=%b want=0", line_err); end
    pulse_clr(); #1;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_short_line();
    exp_din = 12'h1B2;
    clr_mon();
    frame_start();
    send_line(3, 8'hA1, 8'hB2);
    for (int l = 1; l < VL; l++) send_line(HP, 8'hA1, 8'hB2);
    frame_end();
    #1;
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL short_line_err got=%b want=1", line_err); end
    n_cmp++; if (wr_cnt !== 15) begin n_bad++; $display("FAIL short_writes got=%0d want=15", wr_cnt); end
    pulse_clr(); #1;
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL short_clear got=%b want=0", line_err); end
    clr_mon();
    send_frame(VL + 1, 8'hA1, 8'hB2);
    #1;
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL five_lines_err got=%b want=1", line_err); end
    n_cmp++; if (wr_cnt !== 20) begin n_bad++; $display("FAIL five_lines_writes got=%0d want=20", wr_cnt); end
    pulse_clr();
    // vsync rising while href is still high closes a short partial line
    clr_mon();
    frame_start();
    for (int l = 1; l < VL; l++) send_line(HP, 8'hA1, 8'hB2);
    send_pix(8'hA1, 8'hB2);
    send_pix(8'hA1, 8'hB2);
    @(negedge clk); cam_vsync = 1'b1;
    @(negedge clk); cam_href = 1'b0; cam_data = 8'h00;
    idle(4); #1;
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL partial_line_err got=%b want=1", line_err); end
    n_cmp++; if (wr_cnt !== 14) begin n_bad++; $display("FAIL partial_writes got=%0d want=14", wr_cnt); end
    n_cmp++; if (fd_cnt !== 1) begin n_bad++; $display("FAIL partial_frame_done got=%0d want=1", fd_cnt); end
    pulse_clr();
  endtask

  task automatic test_wait_and_reset();
    exp_din = 12'h1B2;
    clr_mon();
    send_line(HP, 8'hA1, 8'hB2);
    idle(2); #1;
    n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL wait_href_writes got=%0d want=0", wr_cnt); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL wait_href_line_err got=%b want=0", line_err); end
    frame_start();
    send_line(2, 8'hA1, 8'hB2);
    send_pix(8'hA1, 8'hB2);
    @(negedge clk); cam_data = 8'hA1;
    #1;
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL pre_reset_line_err got=%b want=1", line_err); end
    @(negedge clk); rst = 1'b1;
    #1;
    n_cmp++; if (fifo_din !== 12'h000) begin n_bad++; $display("FAIL midreset_din got=%h want=000", fifo_din); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL midreset_line_err got=%b want=0", line_err); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL midreset_wr_en got=%b want=0", fifo_wr_en); end
    idle(2);
    @(negedge clk); rst = 1'b0;
    clr_mon();
    send_line(HP, 8'hA1, 8'hB2);
    @(negedge clk); cam_vsync = 1'b1;
    idle(3); #1;
    n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL post_reset_writes got=%0d want=0", wr_cnt); end
    send_frame(VL, 8'hA1, 8'hB2);
    #1;
    n_cmp++; if (wr_cnt !== 16) begin n_bad++; $display("FAIL resume_writes got=%0d want=16", wr_cnt); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL resume_line_err got=%b want=0", line_err); end
  endtask

  task automatic test_clr_collision();
    exp_din = 12'h1B2;
    clr_mon();
    frame_start();
    for (int p = 0; p < 3; p++) send_pix(8'hA1, 8'hB2);
    @(negedge clk); cam_href = 1'b0; cam_data = 8'h00; err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    for (int l = 1; l < VL; l++) send_line(HP, 8'hA1, 8'hB2);
    frame_end();
    #1;
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL collision_line_err got=%b want=1", line_err); end
    n_cmp++; if (wr_cnt !== 15) begin n_bad++; $display("FAIL collision_writes got=%0d want=15", wr_cnt); end
    pulse_clr(); #1;
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL collision_clear got=%b want=0", line_err); end
  endtask

  task automatic test_frame_skip();
    exp_din = 12'h1B2;
    for (int f = 0; f < 3; f++) begin
      clr_mon();
      send_frame(VL, 8'hA1, 8'hB2);
      #1;
      n_cmp++; if (wr_cnt !== ((f == 1) ? 0 : 16)) begin n_bad++; $display("FAIL skip_writes frame=%0d got=%0d want=%0d", f, wr_cnt, (f == 1) ? 0 : 16); end
      n_cmp++; if (fd_cnt !== 1) begin n_bad++; $display("FAIL skip_frame_done frame=%0d got=%0d want=1", f, fd_cnt); end
    end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL skip_line_err got=%b want=0", line_err); end
  endtask

  initial begin
    test_reset();
`ifdef CAM_FRAME_SKIP_EN
    test_frame_skip();
`else
    test_basic_frame();
    test_overflow();
    test_short_line();
    test_wait_and_reset();
    test_clr_collision();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
